// File: rtl/pipe_pkg.sv
// Shared constants and slot-action decode for the pipelined control-word register.
package pipe_pkg;

  localparam int unsigned DEF_WIDTH   = 2;
  localparam logic [DEF_WIDTH-1:0] DEF_NOP = '0;
  localparam int unsigned STALL_CNT_W = 16;
  localparam int unsigned MAX_DEPTH   = 8;

  typedef enum logic [1:0] {
    SLOT_LOAD,
    SLOT_HOLD,
    SLOT_FLUSH,
    SLOT_RESET
  } slot_op_e;

  // Priority: reset > flush > stall > load.
  function automatic slot_op_e slot_op(input logic reset, input logic flush,
                                       input logic stall);
    slot_op_e op;
    if (reset)      op = SLOT_RESET;
    else if (flush) op = SLOT_FLUSH;
    else if (stall) op = SLOT_HOLD;
    else            op = SLOT_LOAD;
    return op;
  endfunction

endpackage

// File: rtl/pipe_ctrl_slot.sv
// One pipeline stage: control word plus valid bit with load/hold/flush/reset.
module pipe_ctrl_slot
  import pipe_pkg::*;
#(
  parameter int unsigned          WIDTH     = DEF_WIDTH,
  parameter logic [WIDTH-1:0]     NOP_VALUE = WIDTH'(DEF_NOP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             flush,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
);

  slot_op_e op;

  always_comb begin
    op = slot_op(reset, flush, stall);
  end

  // An invalid stage always carries NOP_VALUE, whatever arrives on d.
  always_ff @(posedge clk) begin
    unique case (op)
      SLOT_RESET, SLOT_FLUSH: begin
        q       <= NOP_VALUE;
        q_valid <= 1'b0;
      end
      SLOT_HOLD: begin
        q       <= q;
        q_valid <= q_valid;
      end
      default: begin
        q       <= d_valid ? d : NOP_VALUE;
        q_valid <= d_valid;
      end
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_reg.sv
// DEPTH-stage control-word pipeline with stall/flush; the stall_cnt
// performance counter exists only when PIPE_CTRL_REG_PERF_EN is defined.
module pipe_ctrl_reg
  import pipe_pkg::*;
#(
  parameter int unsigned      WIDTH     = DEF_WIDTH,
  parameter int unsigned      DEPTH     = 1,
  parameter logic [WIDTH-1:0] NOP_VALUE = WIDTH'(DEF_NOP)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  input  logic             d_valid,
  input  logic             stall,
  input  logic             flush,
  output logic [WIDTH-1:0] q,
  output logic             q_valid
`ifdef PIPE_CTRL_REG_PERF_EN
  ,
  output logic [STALL_CNT_W-1:0] stall_cnt
`endif
);

  if (DEPTH < 1 || DEPTH > MAX_DEPTH) begin : g_depth_check
    $error("pipe_ctrl_reg: DEPTH must be within 1..8");
  end

  // Element 0 is the upstream input; element k+1 is the output of slot k.
  logic [WIDTH-1:0] stage_data  [DEPTH+1];
  logic             stage_valid [DEPTH+1];

  assign stage_data[0]  = d;
  assign stage_valid[0] = d_valid;

  for (genvar i = 0; i < DEPTH; i++) begin : g_slot
    pipe_ctrl_slot #(
      .WIDTH     (WIDTH),
      .NOP_VALUE (NOP_VALUE)
    ) u_slot (
      .clk     (clk),
      .reset   (reset),
      .stall   (stall),
      .flush   (flush),
      .d       (stage_data[i]),
      .d_valid (stage_valid[i]),
      .q       (stage_data[i+1]),
      .q_valid (stage_valid[i+1])
    );
  end

  assign q       = stage_data[DEPTH];
  assign q_valid = stage_valid[DEPTH];

`ifdef PIPE_CTRL_REG_PERF_EN
  // Stall cycles overridden by flush are not real stalls and are not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall && !flush && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + STALL_CNT_W'(1);
    end
  end
`endif

endmodule
